// File: rtl/cart_map_arb.sv
// cart_map_arb: registered cartridge-bus selector for the SNES core.
// Routes one of NCH+1 mapper channels onto the shared ROM/BSRAM/CPU bus.
// Channel 0 is the base mapper; channel k (1..NCH) is keyed by map_active[k-1].
// Every channel change passes through a drain window with all strobes
// forced inactive. Multi-hot requests park the bus in a safe fault state.
// Optional build macro: CART_MAP_STATS_EN adds switch_cnt / fault_cnt.
module cart_map_arb #(
    parameter int NCH       = 4,
    parameter int ROM_AW    = 24,
    parameter int RAM_AW    = 20,
    parameter int DRAIN_CYC = 2
) (
    input  logic                      mclk,
    input  logic                      rst,
    input  logic [NCH-1:0]            map_active,
    input  logic [(NCH+1)*8-1:0]      ch_do,
    input  logic [NCH:0]              ch_irq_n,
    input  logic [(NCH+1)*ROM_AW-1:0] ch_rom_addr,
    input  logic [NCH:0]              ch_rom_ce_n,
    input  logic [NCH:0]              ch_rom_oe_n,
    input  logic [NCH:0]              ch_rom_word,
    input  logic [(NCH+1)*RAM_AW-1:0] ch_bsram_addr,
    input  logic [(NCH+1)*8-1:0]      ch_bsram_d,
    input  logic [NCH:0]              ch_bsram_ce_n,
    input  logic [NCH:0]              ch_bsram_oe_n,
    input  logic [NCH:0]              ch_bsram_we_n,
    output logic [7:0]                di,
    output logic                      irq_n,
    output logic [ROM_AW-1:0]         rom_addr,
    output logic                      rom_ce_n,
    output logic                      rom_oe_n,
    output logic                      rom_word,
    output logic [RAM_AW-1:0]         bsram_addr,
    output logic [7:0]                bsram_d,
    output logic                      bsram_ce_n,
    output logic                      bsram_oe_n,
    output logic                      bsram_we_n,
    output logic [3:0]                cur_sel,
    output logic                      switching,
    output logic                      fault
`ifdef CART_MAP_STATS_EN
    ,
    output logic [15:0]               switch_cnt,
    output logic [7:0]                fault_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_FAULT
    } state_t;

    // Counter value loaded on entering or restarting a drain; the drain
    // ends on the edge that sees the counter at zero.
    localparam logic [3:0] CNT_LOAD = 4'(DRAIN_CYC - 1);

    state_t      state, state_d;
    logic [3:0]  nxt, nxt_d;
    logic [3:0]  cnt, cnt_d;
    logic [3:0]  cur_sel_d;
    logic        fault_d;

    logic [3:0]  req;
    logic        req_bad;
    logic [3:0]  route_sel;
    logic        pass;
    logic        safe;

    // Selected-channel view of the input buses.
    logic [7:0]        m_do;
    logic              m_irq_n;
    logic [ROM_AW-1:0] m_rom_addr;
    logic              m_rom_ce_n, m_rom_oe_n, m_rom_word;
    logic [RAM_AW-1:0] m_bsram_addr;
    logic [7:0]        m_bsram_d;
    logic              m_bsram_ce_n, m_bsram_oe_n, m_bsram_we_n;

    // Next values of the registered bus outputs.
    logic [7:0]        di_d;
    logic              irq_n_d;
    logic [ROM_AW-1:0] rom_addr_d;
    logic              rom_ce_n_d, rom_oe_n_d, rom_word_d;
    logic [RAM_AW-1:0] bsram_addr_d;
    logic [7:0]        bsram_d_d;
    logic              bsram_ce_n_d, bsram_oe_n_d, bsram_we_n_d;

    // Decode map_active into a channel index; a second set bit flags req_bad.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise an unassigned path infers a latch.
        req     = '0;
        req_bad = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (map_active[k]) begin
                if (req != 4'd0) req_bad = 1'b1;
                req = 4'(k + 1);
            end
        end
    end

    // Channel multiplexer, indexed by route_sel; channel 0 is the fallback.
    always_comb begin
        m_do         = ch_do[7:0];
        m_irq_n      = ch_irq_n[0];
        m_rom_addr   = ch_rom_addr[ROM_AW-1:0];
        m_rom_ce_n   = ch_rom_ce_n[0];
        m_rom_oe_n   = ch_rom_oe_n[0];
        m_rom_word   = ch_rom_word[0];
        m_bsram_addr = ch_bsram_addr[RAM_AW-1:0];
        m_bsram_d    = ch_bsram_d[7:0];
        m_bsram_ce_n = ch_bsram_ce_n[0];
        m_bsram_oe_n = ch_bsram_oe_n[0];
        m_bsram_we_n = ch_bsram_we_n[0];
        for (int k = 1; k <= NCH; k++) begin
            if (route_sel == 4'(k)) begin
                m_do         = ch_do[8*k +: 8];
                m_irq_n      = ch_irq_n[k];
                m_rom_addr   = ch_rom_addr[ROM_AW*k +: ROM_AW];
                m_rom_ce_n   = ch_rom_ce_n[k];
                m_rom_oe_n   = ch_rom_oe_n[k];
                m_rom_word   = ch_rom_word[k];
                m_bsram_addr = ch_bsram_addr[RAM_AW*k +: RAM_AW];
                m_bsram_d    = ch_bsram_d[8*k +: 8];
                m_bsram_ce_n = ch_bsram_ce_n[k];
                m_bsram_oe_n = ch_bsram_oe_n[k];
                m_bsram_we_n = ch_bsram_we_n[k];
            end
        end
    end

    // Next-state logic: decide RUN/DRAIN/FAULT and whether to pass or park the bus.
    always_comb begin
        state_d   = state;
        nxt_d     = nxt;
        cnt_d     = cnt;
        cur_sel_d = cur_sel;
        fault_d   = fault;
        route_sel = cur_sel;
        pass      = 1'b0;
        safe      = 1'b0;

        unique case (state)
            ST_RUN: begin
                if (req_bad) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    safe    = 1'b1;
                end else if (req != cur_sel) begin
                    // Park the bus on this very edge so old strobes never
                    // meet new data.
                    state_d = ST_DRAIN;
                    nxt_d   = req;
                    cnt_d   = CNT_LOAD;
                    safe    = 1'b1;
                end else begin
                    pass = 1'b1;
                end
            end

            ST_DRAIN: begin
                if (req_bad) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    safe    = 1'b1;
                end else if (req != nxt) begin
                    nxt_d = req;
                    cnt_d = CNT_LOAD;
                    safe  = 1'b1;
                end else if (cnt == 4'd0) begin
                    // Drain over: the new channel is routed on this same edge.
                    state_d   = ST_RUN;
                    cur_sel_d = nxt;
                    route_sel = nxt;
                    pass      = 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                    safe  = 1'b1;
                end
            end

            ST_FAULT: begin
                if (!req_bad) begin
                    state_d = ST_DRAIN;
                    nxt_d   = req;
                    cnt_d   = CNT_LOAD;
                end
                safe = 1'b1;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Next bus values: pass the routed channel, force safe strobes, or hold.
    always_comb begin
        di_d         = di;
        irq_n_d      = irq_n;
        rom_addr_d   = rom_addr;
        rom_ce_n_d   = rom_ce_n;
        rom_oe_n_d   = rom_oe_n;
        rom_word_d   = rom_word;
        bsram_addr_d = bsram_addr;
        bsram_d_d    = bsram_d;
        bsram_ce_n_d = bsram_ce_n;
        bsram_oe_n_d = bsram_oe_n;
        bsram_we_n_d = bsram_we_n;
        if (pass) begin
            di_d         = m_do;
            irq_n_d      = m_irq_n;
            rom_addr_d   = m_rom_addr;
            rom_ce_n_d   = m_rom_ce_n;
            rom_oe_n_d   = m_rom_oe_n;
            rom_word_d   = m_rom_word;
            bsram_addr_d = m_bsram_addr;
            bsram_d_d    = m_bsram_d;
            bsram_ce_n_d = m_bsram_ce_n;
            bsram_oe_n_d = m_bsram_oe_n;
            bsram_we_n_d = m_bsram_we_n;
        end else if (safe) begin
            // Addresses, write data and rom_word keep their last values.
            di_d         = 8'hFF;
            irq_n_d      = 1'b1;
            rom_ce_n_d   = 1'b1;
            rom_oe_n_d   = 1'b1;
            bsram_ce_n_d = 1'b1;
            bsram_oe_n_d = 1'b1;
            bsram_we_n_d = 1'b1;
        end
    end

    // State and registered outputs, with synchronous reset to an idle bus.
    always_ff @(posedge mclk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state      <= ST_RUN;
            nxt        <= '0;
            cnt        <= '0;
            cur_sel    <= '0;
            fault      <= 1'b0;
            switching  <= 1'b0;
            di         <= '0;
            irq_n      <= 1'b1;
            rom_addr   <= '0;
            rom_ce_n   <= 1'b1;
            rom_oe_n   <= 1'b1;
            rom_word   <= 1'b0;
            bsram_addr <= '0;
            bsram_d    <= '0;
            bsram_ce_n <= 1'b1;
            bsram_oe_n <= 1'b1;
            bsram_we_n <= 1'b1;
        end else begin
            state      <= state_d;
            nxt        <= nxt_d;
            cnt        <= cnt_d;
            cur_sel    <= cur_sel_d;
            fault      <= fault_d;
            switching  <= (state_d == ST_DRAIN);
            di         <= di_d;
            irq_n      <= irq_n_d;
            rom_addr   <= rom_addr_d;
            rom_ce_n   <= rom_ce_n_d;
            rom_oe_n   <= rom_oe_n_d;
            rom_word   <= rom_word_d;
            bsram_addr <= bsram_addr_d;
            bsram_d    <= bsram_d_d;
            bsram_ce_n <= bsram_ce_n_d;
            bsram_oe_n <= bsram_oe_n_d;
            bsram_we_n <= bsram_we_n_d;
        end
    end

`ifdef CART_MAP_STATS_EN
    // Event counters: completed drains (wrapping) and fault entries (saturating).
    always_ff @(posedge mclk) begin
        if (rst) begin
            switch_cnt <= '0;
            fault_cnt  <= '0;
        end else begin
            if (state == ST_DRAIN && state_d == ST_RUN)
                switch_cnt <= switch_cnt + 16'd1;
            if (state != ST_FAULT && state_d == ST_FAULT && fault_cnt != 8'hFF)
                fault_cnt <= fault_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cart_map_arb.sv
// Self-checking bench for cart_map_arb: directed scenarios plus randomized
// traffic, all compared against a cycle-level behavioural model.
module tb_cart_map_arb;

    localparam int NCH       = 4;
    localparam int ROM_AW    = 24;
    localparam int RAM_AW    = 20;
    localparam int DRAIN_CYC = 2;

    logic mclk = 1'b0;
    always #5 mclk = ~mclk;

    logic           rst;
    logic [NCH-1:0] map_active;

    // Per-channel stimulus, packed onto the DUT buses below.
    logic [7:0]        c_do[NCH+1];
    logic              c_irq_n[NCH+1];
    logic [ROM_AW-1:0] c_rom_addr[NCH+1];
    logic              c_rom_ce_n[NCH+1], c_rom_oe_n[NCH+1], c_rom_word[NCH+1];
    logic [RAM_AW-1:0] c_bsram_addr[NCH+1];
    logic [7:0]        c_bsram_d[NCH+1];
    logic              c_bsram_ce_n[NCH+1], c_bsram_oe_n[NCH+1], c_bsram_we_n[NCH+1];

    logic [(NCH+1)*8-1:0]      ch_do;
    logic [NCH:0]              ch_irq_n;
    logic [(NCH+1)*ROM_AW-1:0] ch_rom_addr;
    logic [NCH:0]              ch_rom_ce_n, ch_rom_oe_n, ch_rom_word;
    logic [(NCH+1)*RAM_AW-1:0] ch_bsram_addr;
    logic [(NCH+1)*8-1:0]      ch_bsram_d;
    logic [NCH:0]              ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n;

    always_comb begin
        for (int k = 0; k <= NCH; k++) begin
            ch_do[8*k +: 8]                 = c_do[k];
            ch_irq_n[k]                     = c_irq_n[k];
            ch_rom_addr[ROM_AW*k +: ROM_AW] = c_rom_addr[k];
            ch_rom_ce_n[k]                  = c_rom_ce_n[k];
            ch_rom_oe_n[k]                  = c_rom_oe_n[k];
            ch_rom_word[k]                  = c_rom_word[k];
            ch_bsram_addr[RAM_AW*k +: RAM_AW] = c_bsram_addr[k];
            ch_bsram_d[8*k +: 8]            = c_bsram_d[k];
            ch_bsram_ce_n[k]                = c_bsram_ce_n[k];
            ch_bsram_oe_n[k]                = c_bsram_oe_n[k];
            ch_bsram_we_n[k]                = c_bsram_we_n[k];
        end
    end

    logic [7:0]        di;
    logic              irq_n;
    logic [ROM_AW-1:0] rom_addr;
    logic              rom_ce_n, rom_oe_n, rom_word;
    logic [RAM_AW-1:0] bsram_addr;
    logic [7:0]        bsram_d;
    logic              bsram_ce_n, bsram_oe_n, bsram_we_n;
    logic [3:0]        cur_sel;
    logic              switching;
    logic              fault;
`ifdef CART_MAP_STATS_EN
    logic [15:0]       switch_cnt;
    logic [7:0]        fault_cnt;
`endif

    cart_map_arb #(
        .NCH(NCH), .ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .mclk(mclk), .rst(rst), .map_active(map_active),
        .ch_do(ch_do), .ch_irq_n(ch_irq_n), .ch_rom_addr(ch_rom_addr),
        .ch_rom_ce_n(ch_rom_ce_n), .ch_rom_oe_n(ch_rom_oe_n), .ch_rom_word(ch_rom_word),
        .ch_bsram_addr(ch_bsram_addr), .ch_bsram_d(ch_bsram_d),
        .ch_bsram_ce_n(ch_bsram_ce_n), .ch_bsram_oe_n(ch_bsram_oe_n),
        .ch_bsram_we_n(ch_bsram_we_n),
        .di(di), .irq_n(irq_n), .rom_addr(rom_addr), .rom_ce_n(rom_ce_n),
        .rom_oe_n(rom_oe_n), .rom_word(rom_word), .bsram_addr(bsram_addr),
        .bsram_d(bsram_d), .bsram_ce_n(bsram_ce_n), .bsram_oe_n(bsram_oe_n),
        .bsram_we_n(bsram_we_n), .cur_sel(cur_sel), .switching(switching),
        .fault(fault)
`ifdef CART_MAP_STATS_EN
        , .switch_cnt(switch_cnt), .fault_cnt(fault_cnt)
`endif
    );

    typedef struct packed {
        logic [7:0]        di;
        logic              irq_n;
        logic [ROM_AW-1:0] rom_addr;
        logic              rom_ce_n, rom_oe_n, rom_word;
        logic [RAM_AW-1:0] bsram_addr;
        logic [7:0]        bsram_d;
        logic              bsram_ce_n, bsram_oe_n, bsram_we_n;
        logic [3:0]        cur_sel;
        logic              switching;
        logic              fault;
    } outs_t;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    // Behavioural model: mode 0 = routing, 1 = draining, 2 = faulted.
    outs_t exp_o;
    int    m_mode, m_sel, m_target, m_safe_done;
    bit    m_fault;
    int    m_switches, m_faults;

    function automatic outs_t dut_outs();
        return {di, irq_n, rom_addr, rom_ce_n, rom_oe_n, rom_word, bsram_addr,
                bsram_d, bsram_ce_n, bsram_oe_n, bsram_we_n, cur_sel, switching, fault};
    endfunction

    task automatic model_edge();
        outs_t n;
        int    ones, req, route;
        bit    safe;
        n = exp_o;
        if (rst) begin
            m_mode = 0; m_sel = 0; m_target = 0; m_safe_done = 0; m_fault = 0;
            m_switches = 0; m_faults = 0;
            n = '0;
            n.irq_n = 1; n.rom_ce_n = 1; n.rom_oe_n = 1;
            n.bsram_ce_n = 1; n.bsram_oe_n = 1; n.bsram_we_n = 1;
            exp_o = n;
            return;
        end
        ones = $countones(map_active);
        req = 0;
        for (int i = 0; i < NCH; i++) if (map_active[i]) req = i + 1;
        safe = 0;
        route = -1;
        if (m_mode == 0) begin
            if (ones > 1) begin
                m_mode = 2; m_fault = 1; m_faults++; safe = 1;
            end else if (req != m_sel) begin
                m_mode = 1; m_target = req; m_safe_done = 1; safe = 1;
            end else route = m_sel;
        end else if (m_mode == 1) begin
            if (ones > 1) begin
                m_mode = 2; m_fault = 1; m_faults++; safe = 1;
            end else if (req != m_target) begin
                m_target = req; m_safe_done = 1; safe = 1;
            end else if (m_safe_done >= DRAIN_CYC) begin
                m_mode = 0; m_sel = m_target; route = m_sel; m_switches++;
            end else begin
                m_safe_done++; safe = 1;
            end
        end else begin
            if (ones <= 1) begin
                m_mode = 1; m_target = req; m_safe_done = 1;
            end
            safe = 1;
        end
        if (route >= 0) begin
            n.di = c_do[route]; n.irq_n = c_irq_n[route];
            n.rom_addr = c_rom_addr[route]; n.rom_ce_n = c_rom_ce_n[route];
            n.rom_oe_n = c_rom_oe_n[route]; n.rom_word = c_rom_word[route];
            n.bsram_addr = c_bsram_addr[route]; n.bsram_d = c_bsram_d[route];
            n.bsram_ce_n = c_bsram_ce_n[route]; n.bsram_oe_n = c_bsram_oe_n[route];
            n.bsram_we_n = c_bsram_we_n[route];
        end
        if (safe) begin
            n.di = 8'hFF; n.irq_n = 1; n.rom_ce_n = 1; n.rom_oe_n = 1;
            n.bsram_ce_n = 1; n.bsram_oe_n = 1; n.bsram_we_n = 1;
        end
        n.cur_sel   = 4'(m_sel);
        n.switching = (m_mode == 1);
        n.fault     = m_fault;
        exp_o = n;
    endtask

    task automatic randomize_channels();
        for (int k = 0; k <= NCH; k++) begin
            c_do[k] = 8'($urandom); c_irq_n[k] = 1'($urandom);
            c_rom_addr[k] = ROM_AW'($urandom); c_rom_ce_n[k] = 1'($urandom);
            c_rom_oe_n[k] = 1'($urandom); c_rom_word[k] = 1'($urandom);
            c_bsram_addr[k] = RAM_AW'($urandom); c_bsram_d[k] = 8'($urandom);
            c_bsram_ce_n[k] = 1'($urandom); c_bsram_oe_n[k] = 1'($urandom);
            c_bsram_we_n[k] = 1'($urandom);
        end
    endtask

    // Advance one edge: model first (same sampled inputs), then sample #1 later.
    task automatic step();
        model_edge();
        @(posedge mclk);
        #1;
        cycle++;
    endtask

    task automatic do_reset();
        rst = 1; map_active = '0;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; map_active = '0;
        randomize_channels();
        c_rom_addr[0] = 24'h123456; c_rom_ce_n[0] = 1'b0;
        for (int i = 0; i < 3; i++) step();
        tests++;
        if ({irq_n, rom_ce_n, rom_oe_n, bsram_ce_n, bsram_oe_n, bsram_we_n} !== 6'h3F ||
            di !== 8'h00 || rom_addr !== '0 || bsram_addr !== '0 || bsram_d !== 8'h00 ||
            rom_word !== 1'b0 || cur_sel !== 4'd0 || switching !== 1'b0 || fault !== 1'b0) begin
            $display("FAIL reset_state got=%h expected idle bus", dut_outs());
            fails++;
        end
        rst = 0;
        step(); step();
        tests++;
        if (rom_addr !== 24'h123456 || rom_ce_n !== 1'b0 || cur_sel !== 4'd0) begin
            $display("FAIL default_route rom_addr=%h rom_ce_n=%b cur_sel=%0d want 123456/0/0",
                     rom_addr, rom_ce_n, cur_sel);
            fails++;
        end
        tests++;
        if (dut_outs() !== exp_o) begin
            $display("FAIL reset_model got=%h want=%h", dut_outs(), exp_o);
            fails++;
        end
    endtask

    task automatic test_clean_switch();
        int nsafe;
        logic [ROM_AW-1:0] prev_addr;
        logic [7:0] prev_do;
        nsafe = 0;
        map_active = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            randomize_channels();
            step();
            tests++;
            if (dut_outs() !== exp_o) begin
                $display("FAIL clean_switch c%0d got=%h want=%h", cycle, dut_outs(), exp_o);
                fails++;
            end
            if (switching === 1'b1) begin
                nsafe++;
                tests++;
                if ({rom_ce_n, rom_oe_n, bsram_ce_n, bsram_oe_n, bsram_we_n, irq_n} !== 6'h3F ||
                    di !== 8'hFF) begin
                    $display("FAIL drain_safe strobes=%b di=%h want 111111/FF",
                             {rom_ce_n, rom_oe_n, bsram_ce_n, bsram_oe_n, bsram_we_n, irq_n}, di);
                    fails++;
                end
            end
        end
        tests++;
        if (nsafe != DRAIN_CYC || cur_sel !== 4'd3) begin
            $display("FAIL clean_switch_len drain=%0d cur_sel=%0d want %0d/3", nsafe, cur_sel, DRAIN_CYC);
            fails++;
        end
        randomize_channels();
        prev_addr = c_rom_addr[3]; prev_do = c_do[3];
        step();
        tests++;
        if (rom_addr !== prev_addr || di !== prev_do) begin
            $display("FAIL ch3_latency rom_addr=%h di=%h want %h/%h", rom_addr, di, prev_addr, prev_do);
            fails++;
        end
    endtask

    task automatic test_retarget();
        int nsafe;
        bit saw_ch1;
        do_reset();
        map_active = '0;
        step(); step();
        saw_ch1 = 0; nsafe = 0;
        map_active = 4'b0001;
        step(); step();
        map_active = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            randomize_channels();
            step();
            if (cur_sel === 4'd1) saw_ch1 = 1;
            if (switching === 1'b1) nsafe++;
            tests++;
            if (dut_outs() !== exp_o) begin
                $display("FAIL retarget c%0d got=%h want=%h", cycle, dut_outs(), exp_o);
                fails++;
            end
        end
        tests++;
        if (cur_sel !== 4'd4 || saw_ch1 || nsafe != DRAIN_CYC) begin
            $display("FAIL retarget_end cur_sel=%0d saw_ch1=%0d drain=%0d want 4/0/%0d",
                     cur_sel, saw_ch1, nsafe, DRAIN_CYC);
            fails++;
        end
    endtask

    task automatic test_multi_hot();
        int nsafe;
        nsafe = 0;
        map_active = 4'b0011;
        step(); step();
        tests++;
        if (fault !== 1'b1 || {rom_ce_n, rom_oe_n, bsram_ce_n, bsram_oe_n, bsram_we_n} !== 5'h1F ||
            switching !== 1'b0) begin
            $display("FAIL multi_hot fault=%b strobes=%b switching=%b want 1/11111/0",
                     fault, {rom_ce_n, rom_oe_n, bsram_ce_n, bsram_oe_n, bsram_we_n}, switching);
            fails++;
        end
        map_active = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            randomize_channels();
            step();
            if (switching === 1'b1) nsafe++;
            tests++;
            if (dut_outs() !== exp_o) begin
                $display("FAIL fault_recover c%0d got=%h want=%h", cycle, dut_outs(), exp_o);
                fails++;
            end
        end
        tests++;
        if (cur_sel !== 4'd2 || fault !== 1'b1 || nsafe != DRAIN_CYC) begin
            $display("FAIL fault_sticky cur_sel=%0d fault=%b drain=%0d want 2/1/%0d",
                     cur_sel, fault, nsafe, DRAIN_CYC);
            fails++;
        end
        do_reset();
        tests++;
        if (fault !== 1'b0) begin
            $display("FAIL fault_clear fault=%b want 0", fault);
            fails++;
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        map_active = '0; step();
        map_active = 4'b0001; step();
        rst = 1; step();
        tests++;
        if ({irq_n, rom_ce_n, rom_oe_n, bsram_ce_n, bsram_oe_n, bsram_we_n} !== 6'h3F ||
            cur_sel !== 4'd0 || switching !== 1'b0 || fault !== 1'b0) begin
            $display("FAIL reset_mid_drain got=%h", dut_outs());
            fails++;
        end
        rst = 0;
        map_active = 4'b1100; step();
        rst = 1; step();
        tests++;
        if (dut_outs() !== exp_o || fault !== 1'b0) begin
            $display("FAIL reset_mid_fault got=%h want=%h", dut_outs(), exp_o);
            fails++;
        end
        rst = 0;
    endtask

    task automatic test_random();
        int r, a, b;
        map_active = '0;
        for (int i = 0; i < 600; i++) begin
            randomize_channels();
            r = $urandom_range(0, 99);
            if (r >= 60 && r < 75) map_active = '0;
            else if (r >= 75 && r < 95) begin
                map_active = '0; map_active[$urandom_range(0, NCH-1)] = 1'b1;
            end else if (r >= 95) begin
                a = $urandom_range(0, NCH-1);
                b = (a + $urandom_range(1, NCH-1)) % NCH;
                map_active = '0; map_active[a] = 1'b1; map_active[b] = 1'b1;
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
            tests++;
            if (dut_outs() !== exp_o) begin
                $display("FAIL random c%0d got=%h want=%h", cycle, dut_outs(), exp_o);
                fails++;
            end
        end
        rst = 0;
`ifdef CART_MAP_STATS_EN
        tests++;
        if (switch_cnt !== 16'(m_switches) || fault_cnt !== 8'(m_faults > 255 ? 255 : m_faults)) begin
            $display("FAIL random_stats switch_cnt=%0d fault_cnt=%0d want %0d/%0d",
                     switch_cnt, fault_cnt, m_switches, m_faults);
            fails++;
        end
`endif
    endtask

`ifdef CART_MAP_STATS_EN
    task automatic test_stats();
        do_reset();
        map_active = 4'b0001; for (int i = 0; i < 3; i++) step();
        map_active = 4'b0010; for (int i = 0; i < 3; i++) step();
        map_active = 4'b0100; for (int i = 0; i < 3; i++) step();
        map_active = 4'b0011; step();
        map_active = 4'b0001; step();
        map_active = 4'b0110; step(); step(); step();
        tests++;
        if (switch_cnt !== 16'd3 || fault_cnt !== 8'd2) begin
            $display("FAIL stats switch_cnt=%0d fault_cnt=%0d want 3/2", switch_cnt, fault_cnt);
            fails++;
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cycle);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; map_active = '0;
        randomize_channels();
        test_reset();
        test_clean_switch();
        test_retarget();
        test_multi_hot();
        test_reset_mid_drain();
        test_random();
`ifdef CART_MAP_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
